// File: rtl/frame_fifo_write_pkg.sv
// Shared definitions for the frame FIFO write path: state encodings and single-bit constants.
package frame_fifo_write_pkg;

    typedef enum logic [2:0] {
        S_IDLE            = 3'd0,
        S_ACK             = 3'd1,
        S_CHECK_FIFO      = 3'd2,
        S_WRITE_BURST     = 3'd3,
        S_WRITE_BURST_END = 3'd4,
        S_END             = 3'd5
    } state_t;

    localparam logic ZERO = 1'b0;
    localparam logic ONE  = 1'b1;

endpackage

// File: rtl/frame_fifo_write_if.sv
// Bundle of SDRAM user-port, write-FIFO and frame-request signals around the frame writer.
interface frame_fifo_write_if #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 21
);
    logic                     Sdr_init_done;
    logic                     Sdr_busy;
    logic                     App_rd_busy;
    logic                     O_wr_busy;
    logic                     App_wr_en;
    logic [ADDR_BITS-1:0]     App_wr_addr;
    logic [MEM_DATA_BITS-1:0] App_wr_din;
    logic                     fifo_rdreq;
    logic [MEM_DATA_BITS-1:0] fifo_rddata;
    logic [9:0]               rdusedw;
    logic                     write_req;
    logic                     write_req_ack;
    logic                     write_finish;
    logic [ADDR_BITS-1:0]     write_addr_0;
    logic [ADDR_BITS-1:0]     write_addr_1;
    logic [ADDR_BITS-1:0]     write_addr_2;
    logic [ADDR_BITS-1:0]     write_addr_3;
    logic [1:0]               write_addr_index;
    logic [ADDR_BITS-1:0]     write_len;
    logic                     fifo_aclr;

    // The frame writer itself.
    modport master (
        input  Sdr_init_done, Sdr_busy, App_rd_busy, fifo_rddata, rdusedw,
        input  write_req, write_addr_0, write_addr_1, write_addr_2, write_addr_3,
        input  write_addr_index, write_len,
        output O_wr_busy, App_wr_en, App_wr_addr, App_wr_din, fifo_rdreq,
        output write_req_ack, write_finish, fifo_aclr
    );

    // Controller, FIFO and frame source surrounding the writer.
    modport slave (
        output Sdr_init_done, Sdr_busy, App_rd_busy, fifo_rddata, rdusedw,
        output write_req, write_addr_0, write_addr_1, write_addr_2, write_addr_3,
        output write_addr_index, write_len,
        input  O_wr_busy, App_wr_en, App_wr_addr, App_wr_din, fifo_rdreq,
        input  write_req_ack, write_finish, fifo_aclr
    );
endinterface

// File: rtl/frame_fifo_write.sv
// Drains the camera write FIFO into SDRAM in bursts, one frame per write_req.
// Optional FRAME_FIFO_WRITE_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module frame_fifo_write
    import frame_fifo_write_pkg::*;
#(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 21,
    parameter int BURST_BITS    = 9,
    parameter int FIFO_DEPTH    = 512,
    parameter int BURST_SIZE    = 128
) (
    input  logic               mem_clk,
    input  logic               rst,
    frame_fifo_write_if.master bus
`ifdef FRAME_FIFO_WRITE_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    state_t state_reg, state_next;

    logic [2:0]           req_sync_reg;
    logic [ADDR_BITS-1:0] len_d0_reg, len_d1_reg;
    logic [1:0]           index_d0_reg, index_d1_reg;
    logic [ADDR_BITS-1:0] len_latch_reg, wr_cnt_reg, addr_reg;
    logic [BURST_BITS-1:0] burst_len_reg, pop_cnt_reg, beat_cnt_reg;
    logic ack_reg, aclr_reg, rdreq_reg, wr_en_reg, finish_reg, busy_reg;
    logic ack_next, rdreq_next, finish_next, busy_next;

    logic                  req_d2;
    logic [ADDR_BITS-1:0]  remain_len;
    logic [BURST_BITS-1:0] burst_len_calc;
    logic                  fifo_ready, last_beat;
    logic [ADDR_BITS-1:0]  base_addr [4];

    assign req_d2       = req_sync_reg[2];
    assign base_addr[0] = bus.write_addr_0;
    assign base_addr[1] = bus.write_addr_1;
    assign base_addr[2] = bus.write_addr_2;
    assign base_addr[3] = bus.write_addr_3;

    // Remaining words clipped to one burst; the FIFO must already hold the whole burst.
    assign remain_len = len_latch_reg - wr_cnt_reg;
    always_comb begin
        burst_len_calc = remain_len[BURST_BITS-1:0];
        if (remain_len >= ADDR_BITS'(BURST_SIZE))
            burst_len_calc = BURST_BITS'(BURST_SIZE);
    end
    assign fifo_ready = ADDR_BITS'(bus.rdusedw) >= ADDR_BITS'(burst_len_calc);
    assign last_beat  = wr_en_reg && (beat_cnt_reg == burst_len_reg - BURST_BITS'(1));

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:
                if (req_d2 && bus.Sdr_init_done) state_next = S_ACK;
            S_ACK:
                if (!req_d2) state_next = S_CHECK_FIFO;
            S_CHECK_FIFO:
                if (req_d2)
                    state_next = S_ACK;
                else if (burst_len_calc == '0)
                    state_next = S_WRITE_BURST_END;
                else if (fifo_ready && !bus.App_rd_busy && !bus.Sdr_busy)
                    state_next = S_WRITE_BURST;
            S_WRITE_BURST:
                if (last_beat) state_next = S_WRITE_BURST_END;
            S_WRITE_BURST_END:
                if (req_d2)
                    state_next = S_ACK;
                else if (wr_cnt_reg < len_latch_reg)
                    state_next = S_CHECK_FIFO;
                else
                    state_next = S_END;
            S_END:
                state_next = S_IDLE;
            default:
                state_next = S_IDLE;
        endcase
    end

    // Registered outputs are computed one cycle ahead so they line up with the state they belong to.
    always_comb begin
        ack_next    = (state_reg == S_ACK) && req_d2;
        rdreq_next  = ((state_reg == S_CHECK_FIFO) && (state_next == S_WRITE_BURST)) ||
                      ((state_reg == S_WRITE_BURST) && (pop_cnt_reg < burst_len_reg));
        finish_next = (state_next == S_END);
        busy_next   = (state_next == S_WRITE_BURST);
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            req_sync_reg  <= '0;
            len_d0_reg    <= '0;
            len_d1_reg    <= '0;
            index_d0_reg  <= '0;
            index_d1_reg  <= '0;
            len_latch_reg <= '0;
            wr_cnt_reg    <= '0;
            addr_reg      <= '0;
            burst_len_reg <= '0;
            pop_cnt_reg   <= '0;
            beat_cnt_reg  <= '0;
            ack_reg       <= ZERO;
            aclr_reg      <= ZERO;
            rdreq_reg     <= ZERO;
            wr_en_reg     <= ZERO;
            finish_reg    <= ZERO;
            busy_reg      <= ZERO;
        end else begin
            req_sync_reg <= {req_sync_reg[1:0], bus.write_req};
            len_d0_reg   <= bus.write_len;
            len_d1_reg   <= len_d0_reg;
            index_d0_reg <= bus.write_addr_index;
            index_d1_reg <= index_d0_reg;

            ack_reg    <= ack_next;
            aclr_reg   <= ack_next;
            rdreq_reg  <= rdreq_next;
            wr_en_reg  <= rdreq_reg;
            finish_reg <= finish_next;
            busy_reg   <= busy_next;

            if ((state_reg == S_ACK) && req_d2) begin
                len_latch_reg <= len_d1_reg;
                addr_reg      <= base_addr[index_d1_reg];
                wr_cnt_reg    <= '0;
            end else if (wr_en_reg) begin
                addr_reg <= addr_reg + ADDR_BITS'(1);
            end

            if ((state_reg == S_CHECK_FIFO) && (state_next == S_WRITE_BURST)) begin
                burst_len_reg <= burst_len_calc;
                pop_cnt_reg   <= BURST_BITS'(1);
                beat_cnt_reg  <= '0;
            end else if (state_reg == S_WRITE_BURST) begin
                if (rdreq_next) pop_cnt_reg <= pop_cnt_reg + BURST_BITS'(1);
                if (wr_en_reg)  beat_cnt_reg <= beat_cnt_reg + BURST_BITS'(1);
                if (last_beat)  wr_cnt_reg <= wr_cnt_reg + ADDR_BITS'(burst_len_reg);
            end
        end
    end

    assign bus.O_wr_busy     = busy_reg;
    assign bus.App_wr_en     = wr_en_reg;
    assign bus.App_wr_addr   = addr_reg;
    // FIFO data is valid the cycle after the pop, which is exactly the App_wr_en cycle.
    assign bus.App_wr_din    = wr_en_reg ? bus.fifo_rddata : '0;
    assign bus.fifo_rdreq    = rdreq_reg;
    assign bus.write_req_ack = ack_reg;
    assign bus.write_finish  = finish_reg;
    assign bus.fifo_aclr     = aclr_reg;

`ifdef FRAME_FIFO_WRITE_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst)             frame_cnt_reg <= '0;
        else if (finish_reg) frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
    assign frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_frame_fifo_write.sv
// Directed bench for frame_fifo_write: FIFO model, per-beat address/data scoreboard, burst-run tracking.
module tb_frame_fifo_write;
    localparam int D = 32;
    localparam int A = 21;

    logic mem_clk = 1'b0;
    logic rst;
    always #5 mem_clk = ~mem_clk;

    frame_fifo_write_if #(.MEM_DATA_BITS(D), .ADDR_BITS(A)) bus ();

`ifdef FRAME_FIFO_WRITE_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    frame_fifo_write #(
        .MEM_DATA_BITS(D), .ADDR_BITS(A), .BURST_BITS(9), .FIFO_DEPTH(512), .BURST_SIZE(128)
    ) dut (
        .mem_clk(mem_clk),
        .rst(rst),
        .bus(bus)
`ifdef FRAME_FIFO_WRITE_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    logic [D-1:0] fifo_q[$];
    int push_total = 0;
    int pushed = 0;
    logic s_rdreq = 1'b0;
    logic s_aclr = 1'b0;

    logic [A-1:0] exp_base = '0;
    int frame_w0 = 0;
    int beat_idx = 0;
    int last_frame_beats = 0;
    int run_len = 0;
    int runs[$];
    int finishes = 0;
    int finishes_since_rst = 0;
    bit hold_off = 1'b0;

    function automatic logic [D-1:0] word_of(int n);
        return 32'hA500_0000 + 32'(n);
    endfunction

    function automatic logic [A-1:0] base_of(int idx);
        case (idx)
            0:       return 21'h000100;
            1:       return 21'h1FFF00;
            2:       return 21'h040000;
            default: return 21'h0ABCDE;
        endcase
    endfunction

    function automatic logic [63:0] outs();
        return 64'({bus.O_wr_busy, bus.App_wr_en, bus.App_wr_addr, bus.App_wr_din,
                    bus.fifo_rdreq, bus.write_req_ack, bus.write_finish, bus.fifo_aclr});
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: FIFO update just after the edge, scoreboard on the falling edge.
    task automatic tick();
        logic [A-1:0] ea;
        @(posedge mem_clk);
        #1;
        if (s_aclr) begin
            fifo_q.delete();
        end else if (s_rdreq) begin
            chk("fifo_pop_nonempty", 64'(fifo_q.size() == 0), 64'd0);
            if (fifo_q.size() != 0) bus.fifo_rddata = fifo_q.pop_front();
        end
        while (pushed < push_total && fifo_q.size() < 512) begin
            fifo_q.push_back(word_of(pushed));
            pushed++;
        end
        bus.rdusedw = 10'(fifo_q.size());
        @(negedge mem_clk);
        s_rdreq = bus.fifo_rdreq;
        s_aclr  = bus.fifo_aclr;
        if (bus.App_wr_en) begin
            ea = exp_base + A'(beat_idx);
            chk("beat_addr", 64'(bus.App_wr_addr), 64'(ea));
            chk("beat_data", 64'(bus.App_wr_din), 64'(word_of(frame_w0 + beat_idx)));
            chk("beat_busy", 64'(bus.O_wr_busy), 64'd1);
            beat_idx++;
        end
        if (bus.fifo_rdreq) run_len++;
        else if (run_len > 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
        if (hold_off) begin
            chk("held_no_pop", 64'(bus.fifo_rdreq), 64'd0);
            chk("held_not_busy", 64'(bus.O_wr_busy), 64'd0);
        end
        if (bus.write_finish) begin
            finishes++;
            finishes_since_rst++;
        end
    endtask

    task automatic request(int idx, int len);
        int n;
        bus.write_addr_index = idx[1:0];
        bus.write_len        = A'(len);
        bus.write_req        = 1'b1;
        n = 0;
        while (!bus.write_req_ack && n < 400) begin tick(); n++; end
        chk("ack_seen", 64'(bus.write_req_ack), 64'd1);
        chk("aclr_with_ack", 64'(bus.fifo_aclr), 64'd1);
        bus.write_req = 1'b0;
        n = 0;
        while (bus.write_req_ack && n < 20) begin tick(); n++; end
        chk("ack_drop", 64'(bus.write_req_ack), 64'd0);
        chk("aclr_drop", 64'(bus.fifo_aclr), 64'd0);
        last_frame_beats = beat_idx;
        exp_base = base_of(idx);
        frame_w0 = push_total;
        beat_idx = 0;
        run_len  = 0;
        runs.delete();
    endtask

    task automatic wait_finish(string name);
        int n = 0;
        int f0 = finishes;
        while (finishes == f0 && n < 3000) begin tick(); n++; end
        chk({name, "_finish"}, 64'(finishes - f0), 64'd1);
        tick();
        chk({name, "_finish_pulse"}, 64'(bus.write_finish), 64'd0);
        $display("frame %s: beats=%0d bursts=%0d finishes=%0d", name, beat_idx, runs.size(), finishes);
    endtask

    task automatic chk_run(string name, int i, int exp);
        chk(name, 64'(runs.size() > i ? runs[i] : -1), 64'(exp));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.write_req = 1'b0;
        bus.Sdr_init_done = 1'b1;
        bus.Sdr_busy = 1'b0;
        bus.App_rd_busy = 1'b0;
        bus.fifo_rddata = '0;
        bus.rdusedw = '0;
        bus.write_addr_0 = base_of(0);
        bus.write_addr_1 = base_of(1);
        bus.write_addr_2 = base_of(2);
        bus.write_addr_3 = base_of(3);
        bus.write_addr_index = '0;
        bus.write_len = '0;
        repeat (3) tick();
        chk("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_outputs", outs(), 64'd0);

        // 1: 300 words from a base just below the top of memory, FIFO prefilled
        request(1, 300);
        push_total += 512;
        wait_finish("t1");
        chk("t1_beats", 64'(beat_idx), 64'd300);
        chk("t1_nruns", 64'(runs.size()), 64'd3);
        chk_run("t1_run0", 0, 128);
        chk_run("t1_run1", 1, 128);
        chk_run("t1_run2", 2, 44);
        chk("t1_end_addr_wrapped", 64'(bus.App_wr_addr), 64'h00002C);

        // 2: 127 words must not start a burst; the 128th does, one cycle later
        request(0, 128);
        hold_off = 1'b1;
        push_total += 127;
        repeat (15) tick();
        push_total += 1;
        hold_off = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!bus.fifo_rdreq && n < 50);
        chk("t2_start_latency", 64'(n), 64'd2);
        wait_finish("t2");
        chk("t2_beats", 64'(beat_idx), 64'd128);
        chk_run("t2_run0", 0, 128);

        // 3: read path busy holds the writer off for 20 cycles
        bus.App_rd_busy = 1'b1;
        request(2, 64);
        push_total += 64;
        hold_off = 1'b1;
        repeat (20) tick();
        bus.App_rd_busy = 1'b0;
        hold_off = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!bus.fifo_rdreq && n < 50);
        chk("t3_start_latency", 64'(n), 64'd1);
        wait_finish("t3");
        chk("t3_beats", 64'(beat_idx), 64'd64);
        chk_run("t3_run0", 0, 64);

        // 4: new request at beat 50 lets the burst complete, then restarts at a new base
        request(0, 300);
        push_total += 512;
        n = 0;
        while (beat_idx < 50 && n < 2000) begin tick(); n++; end
        chk("t4_reached_beat50", 64'(beat_idx), 64'd50);
        request(3, 40);
        chk("t4_full_burst", 64'(last_frame_beats), 64'd128);
        push_total += 40;
        wait_finish("t4");
        chk("t4_beats", 64'(beat_idx), 64'd40);
        chk_run("t4_run0", 0, 40);
`ifdef FRAME_FIFO_WRITE_FRAME_CNT_EN
        chk("frame_cnt_pre_rst", 64'(frame_cnt), 64'd4);
`endif

        // 5: reset mid-burst, then a clean frame
        request(1, 300);
        push_total += 512;
        n = 0;
        while (beat_idx < 10 && n < 2000) begin tick(); n++; end
        rst = 1'b1;
        #1;
        chk("t5_async_clear", outs(), 64'd0);
        tick();
        chk("t5_held_clear", outs(), 64'd0);
`ifdef FRAME_FIFO_WRITE_FRAME_CNT_EN
        chk("t5_frame_cnt_clear", 64'(frame_cnt), 64'd0);
`endif
        rst = 1'b0;
        finishes_since_rst = 0;
        repeat (2) tick();
        request(2, 40);
        push_total += 40;
        wait_finish("t5");
        chk("t5_beats", 64'(beat_idx), 64'd40);
        chk_run("t5_run0", 0, 40);

        // 6: zero-length frame finishes with no beats
        request(0, 0);
        wait_finish("t6");
        chk("t6_beats", 64'(beat_idx), 64'd0);
        chk("t6_no_runs", 64'(runs.size()), 64'd0);
`ifdef FRAME_FIFO_WRITE_FRAME_CNT_EN
        chk("frame_cnt_post_rst", 64'(frame_cnt), 64'd2);
        chk("frame_cnt_vs_model", 64'(frame_cnt), 64'(finishes_since_rst));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
